// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   state_t    - 3-bit receiver FSM encoding (IDLE/START/DATA/STOP/PARITY)
//   OVERSAMPLE - ticks per bit period
//   MID_SAMPLE - tick count at which the start bit is re-checked (mid-bit)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for an asynchronous, idle-high input.
// Both flops reset to 1 so a line held idle never looks like a start bit
// while coming out of reset.
//   clk_50Mhz - system clock
//   rst       - synchronous, active-high reset
//   d         - asynchronous input
//   q         - synchronised output (two clocks of latency)
module uart_rx_sync (
  input  logic clk_50Mhz,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receiver, LSB first, DBITS data bits,
// SBITS-tick stop bit. Optional even-parity bit when UART_RX_PARITY_EN is
// defined; otherwise parity_err is tied low.
//   clk_50Mhz  - system clock, all logic on posedge
//   rst        - synchronous, active-high reset
//   tick       - one-cycle oversample strobe, 16 per bit period
//   rx         - asynchronous serial line, idle high
//   dout       - last received data word
//   rx_done    - one-cycle strobe: dout/frame_err/parity_err just updated
//   rx_busy    - FSM not in IDLE
//   frame_err  - stop bit sampled low on the last frame
//   parity_err - parity mismatch on the last frame
//
// state  | meaning
// IDLE   | line idle, waiting for a low rx_s
// START  | counting to mid start bit to reject glitches
// DATA   | sampling DBITS data bits at mid-bit
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | waiting SBITS ticks, then sampling the stop bit
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DBITS = 8,
  parameter int SBITS = 16
) (
  input  logic             clk_50Mhz,
  input  logic             rst,
  input  logic             tick,
  input  logic             rx,
  output logic [DBITS-1:0] dout,
  output logic             rx_done,
  output logic             rx_busy,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int CW = $clog2((SBITS > OVERSAMPLE) ? SBITS : OVERSAMPLE);
  localparam int BW = $clog2(DBITS);

  localparam logic [CW-1:0] CNT_MID  = CW'(MID_SAMPLE);
  localparam logic [CW-1:0] CNT_BIT  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_STOP = CW'(SBITS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk_50Mhz (clk_50Mhz),
    .rst       (rst),
    .d         (rx),
    .q         (rx_s)
  );

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [BW-1:0]    bits_q, bits_n;
  logic [DBITS-1:0] sh_q, sh_n;
  logic [DBITS-1:0] dout_n;
  logic             frame_err_n;
  logic             rx_done_n;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_n;
  logic             parity_err_q, parity_err_n;
`endif

  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bits_q    <= '0;
      sh_q      <= '0;
      dout      <= '0;
      frame_err <= 1'b0;
      rx_done   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      bits_q    <= bits_n;
      sh_q      <= sh_n;
      dout      <= dout_n;
      frame_err <= frame_err_n;
      rx_done   <= rx_done_n;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_n;
      parity_err_q <= parity_err_n;
`endif
    end
  end

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    bits_n      = bits_q;
    sh_n        = sh_q;
    dout_n      = dout;
    frame_err_n = frame_err;
    rx_done_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n        = par_q;
    parity_err_n = parity_err_q;
`endif
    case (state_q)
      IDLE: begin
        // Start edge is taken immediately; tick alignment is absorbed by
        // the mid-bit count in START.
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (cnt_q == CNT_MID) begin
            cnt_n = '0;
            if (!rx_s) begin
              state_n = DATA;
              bits_n  = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == CNT_BIT) begin
            cnt_n = '0;
            sh_n  = {rx_s, sh_q[DBITS-1:1]};
            if (bits_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              bits_n = bits_q + 1'b1;
            end
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (cnt_q == CNT_BIT) begin
            cnt_n   = '0;
            par_n   = (^sh_q) ^ rx_s;
            state_n = STOP;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (cnt_q == CNT_STOP) begin
            cnt_n       = '0;
            dout_n      = sh_q;
            frame_err_n = ~rx_s;
            rx_done_n   = 1'b1;
            state_n     = IDLE;
`ifdef UART_RX_PARITY_EN
            parity_err_n = par_q;
`endif
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign rx_busy = (state_q != IDLE);

`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  logic       clk_50Mhz = 1'b0;
  logic       rst;
  logic       tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  uart_receiver #(.DBITS(8), .SBITS(16)) dut (
    .clk_50Mhz  (clk_50Mhz),
    .rst        (rst),
    .tick       (tick),
    .rx         (rx),
    .dout       (dout),
    .rx_done    (rx_done),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #10 clk_50Mhz = ~clk_50Mhz;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total = 0;
  int   strobes = 0;
  int   exp_strobes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // tick generator: one-cycle pulse every 27 clocks
  initial begin
    tick = 1'b0;
    forever begin
      repeat (26) @(negedge clk_50Mhz);
      tick = 1'b1;
      @(negedge clk_50Mhz);
      tick = 1'b0;
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50Mhz);
      while (!tick) @(posedge clk_50Mhz);
    end
    @(negedge clk_50Mhz);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d = d; e.fe = fe; e.pe = pe;
    exp_q.push_back(e);
    exp_strobes++;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val,
                            input logic use_par, input logic par_bit);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    if (use_par) begin
      rx = par_bit;
      wait_ticks(16);
    end
    rx = stop_val;
    wait_ticks(16);
  endtask

  // monitor: every strobe pops one expectation
  always @(negedge clk_50Mhz) begin
    if (rx_done) begin
      strobes++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_rx_done: got dout=%0h expected no strobe", dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("dout", {24'd0, dout}, {24'd0, e.d});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
        check("busy_at_strobe", {31'd0, rx_busy}, 32'd0);
      end
    end
  end

  initial begin
    #(20 * 95000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

`ifdef UART_RX_PARITY_EN
  localparam logic USE_PAR = 1'b1;
`else
  localparam logic USE_PAR = 1'b0;
`endif

  initial begin
    logic [7:0] d81;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk_50Mhz);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_rx_done", {31'd0, rx_done}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    wait_ticks(4);

    // 0xA5 = 1010_0101, four ones -> even parity bit 0
    push_exp(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, USE_PAR, 1'b0);
    wait_ticks(4);
    check("a5_busy_after", {31'd0, rx_busy}, 32'd0);

    // glitch shorter than half a bit
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(20);
    check("glitch_busy", {31'd0, rx_busy}, 32'd0);
    check("glitch_dout", {24'd0, dout}, 32'h0000_00A5);
    check("glitch_strobes", strobes, exp_strobes);

    // 0x3C = 0011_1100, four ones -> parity 0; stop low then break
    push_exp(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, USE_PAR, 1'b0);
    wait_ticks(40);
    check("break_busy", {31'd0, rx_busy}, 32'd1);
    check("break_frame_err_held", {31'd0, frame_err}, 32'd1);
    check("break_strobes", strobes, exp_strobes);
    rst = 1'b1;
    @(negedge clk_50Mhz);
    rst = 1'b0;
    rx  = 1'b1;
    check("break_rst_busy", {31'd0, rx_busy}, 32'd0);
    wait_ticks(24);

    // reset during data bit 3 of 0x81
    d81 = 8'h81;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rx = d81[i];
      wait_ticks(16);
    end
    rx = d81[3];
    wait_ticks(8);
    check("mid_busy_before_rst", {31'd0, rx_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk_50Mhz);
    rst = 1'b0;
    rx  = 1'b1;
    check("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
    check("mid_rst_done", {31'd0, rx_done}, 32'd0);
    wait_ticks(24);
    check("mid_rst_strobes", strobes, exp_strobes);

    // 0x5A = 0101_1010, four ones -> parity 0
    push_exp(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, USE_PAR, 1'b0);

    // back to back, single stop bit each
    push_exp(8'h00, 1'b0, 1'b0);
    push_exp(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, USE_PAR, 1'b0);
    send_frame(8'hFF, 1'b1, USE_PAR, 1'b0);
    wait_ticks(4);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1
    push_exp(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    wait_ticks(4);
    push_exp(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    wait_ticks(4);
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_50Mhz);
    check("queue_drained", exp_q.size(), 32'd0);
    check("total_strobes", strobes, exp_strobes);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
